// File: rtl/seq_shift_add_mul_if.sv
// Operand/result handshake bundle for seq_shift_add_mul.
// The CPU side uses the master modport and the multiplier uses the slave modport.
interface seq_shift_add_mul_if #(
    parameter int WIDTH = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic                 is_signed;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   product;
    logic                 ovf;

    modport master (
        output in_valid, is_signed, a, b, out_ready,
        input  in_ready, out_valid, product, ovf
    );

    modport slave (
        input  in_valid, is_signed, a, b, out_ready,
        output in_ready, out_valid, product, ovf
    );
endinterface

// File: rtl/seq_shift_add_mul.sv
// Iterative shift-and-add multiplier: one partial product per clock, 2*WIDTH-bit signed/unsigned result.
// Optional macro MUL_EARLY_TERM_EN ends the run once the remaining multiplier bits are all zero.
module seq_shift_add_mul #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seq_shift_add_mul_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0]   ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   ONE_C    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(WIDTH - 1);

    state_t               state_r;
    logic [2*WIDTH-1:0]   mcand_r;
    logic [2*WIDTH-1:0]   acc_r;
    logic [2*WIDTH-1:0]   product_r;
    logic [WIDTH-1:0]     mplier_r;
    logic [CNT_W-1:0]     cnt_r;
    logic                 neg_r;
    logic                 sgn_r;
    logic                 ready_en_r;
    logic                 out_valid_r;
    logic                 ovf_r;

    logic                 in_ready_s;
    logic                 accept_s;
    logic                 last_s;
    logic [WIDTH-1:0]     mplier_nxt_s;
    logic [2*WIDTH-1:0]   sum_s;
    logic [2*WIDTH-1:0]   result_s;

    // |x| as an unsigned WIDTH-bit magnitude; the most-negative value maps onto itself.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic sgn);
        return (sgn && x[WIDTH-1]) ? ((~x) + ONE_W) : x;
    endfunction

    function automatic logic ovf_of(input logic [2*WIDTH-1:0] p, input logic sgn);
        logic [WIDTH:0] hi;
        hi = p[2*WIDTH-1:WIDTH-1];
        return sgn ? ~((&hi) | ~(|hi)) : (|p[2*WIDTH-1:WIDTH]);
    endfunction

    // Handshake decode and the current iteration's partial sum.
    always_comb begin
        in_ready_s   = ready_en_r & ((state_r == IDLE) | ((state_r == DONE) & bus.out_ready));
        accept_s     = in_ready_s & bus.in_valid;
        mplier_nxt_s = mplier_r >> 1;
        sum_s        = mplier_r[0] ? (acc_r + mcand_r) : acc_r;
        result_s     = neg_r ? ((~sum_s) + ONE_2W) : sum_s;
`ifdef MUL_EARLY_TERM_EN
        last_s       = (cnt_r == LAST_CNT) | (mplier_nxt_s == {WIDTH{1'b0}});
`else
        last_s       = (cnt_r == LAST_CNT);
`endif
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.product   = product_r;
    assign bus.ovf       = ovf_r;

    // Control FSM with datapath registers; operands are only sampled on an accepting edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            mcand_r     <= {(2*WIDTH){1'b0}};
            acc_r       <= {(2*WIDTH){1'b0}};
            product_r   <= {(2*WIDTH){1'b0}};
            mplier_r    <= {WIDTH{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            neg_r       <= 1'b0;
            sgn_r       <= 1'b0;
            ready_en_r  <= 1'b0;
            out_valid_r <= 1'b0;
            ovf_r       <= 1'b0;
        end else begin
            ready_en_r <= 1'b1;
            if (accept_s) begin
                mcand_r     <= {{WIDTH{1'b0}}, magnitude(bus.a, bus.is_signed)};
                mplier_r    <= magnitude(bus.b, bus.is_signed);
                neg_r       <= bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                sgn_r       <= bus.is_signed;
                acc_r       <= {(2*WIDTH){1'b0}};
                cnt_r       <= {CNT_W{1'b0}};
                out_valid_r <= 1'b0;
                state_r     <= RUN;
            end else begin
                case (state_r)
                    IDLE: begin
                        state_r <= IDLE;
                    end
                    RUN: begin
                        acc_r    <= sum_s;
                        mcand_r  <= mcand_r << 1;
                        mplier_r <= mplier_nxt_s;
                        cnt_r    <= cnt_r + ONE_C;
                        if (last_s) begin
                            product_r   <= result_s;
                            ovf_r       <= ovf_of(result_s, sgn_r);
                            out_valid_r <= 1'b1;
                            state_r     <= DONE;
                        end else begin
                            state_r <= RUN;
                        end
                    end
                    DONE: begin
                        if (bus.out_ready) begin
                            out_valid_r <= 1'b0;
                            state_r     <= IDLE;
                        end else begin
                            state_r <= DONE;
                        end
                    end
                    default: begin
                        out_valid_r <= 1'b0;
                        state_r     <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_seq_shift_add_mul.sv
// Self-checking bench for seq_shift_add_mul (WIDTH=16): directed cases plus randomized ops vs a cycle-level model.
module tb_seq_shift_add_mul;
    localparam int W = 16;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    seq_shift_add_mul_if #(.WIDTH(W)) bus ();

    seq_shift_add_mul #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference arithmetic straight from the definition of the product.
    function automatic void ref_mul(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                    output logic [2*W-1:0] p, output logic o);
        longint r;
        if (s) begin
            r = longint'($signed(a)) * longint'($signed(b));
            o = (r > 32767) || (r < -32768);
        end else begin
            r = longint'(a) * longint'(b);
            o = (r > 65535);
        end
        p = r[2*W-1:0];
    endfunction

    function automatic int ref_lat(input logic [W-1:0] b, input logic s);
        int mag;
        int lat;
        mag = (s && b[W-1]) ? (65536 - int'(b)) : int'(b);
        lat = 1;
        for (int i = 0; i < 17; i++) begin
            if (mag >= (1 << i)) lat = i + 1;
        end
`ifdef MUL_EARLY_TERM_EN
        return lat;
`else
        return W;
`endif
    endfunction

    // Cycle-level model: compares every cycle, then predicts the state after the coming edge.
    initial begin
        bit              m_en, m_run, m_done, m_ovf, pend_o, exp_rdy;
        int              m_left;
        logic [2*W-1:0]  m_prod, pend_p;
        m_en = 0; m_run = 0; m_done = 0; m_left = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_en = 0; m_run = 0; m_done = 0;
                chk("rst_in_ready", bus.in_ready, 0);
                chk("rst_out_valid", bus.out_valid, 0);
                chk("rst_product", bus.product, 0);
                chk("rst_ovf", bus.ovf, 0);
            end else begin
                exp_rdy = m_en && !m_run && (!m_done || bus.out_ready);
                chk("in_ready", bus.in_ready, exp_rdy);
                chk("out_valid", bus.out_valid, m_done);
                if (m_done) begin
                    chk("product", bus.product, m_prod);
                    chk("ovf", bus.ovf, m_ovf);
                end
                if (m_done && bus.out_ready) m_done = 0;
                if (m_run) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_run = 0; m_done = 1; m_prod = pend_p; m_ovf = pend_o;
                    end
                end
                if (bus.in_valid && exp_rdy) begin
                    ref_mul(bus.a, bus.b, bus.is_signed, pend_p, pend_o);
                    m_left = ref_lat(bus.b, bus.is_signed);
                    m_run  = 1;
                end
                m_en = 1;
            end
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, output int waits);
        bit ok;
        ok = 0;
        bus.a = a; bus.b = b; bus.is_signed = s;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        waits = 0;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk);
            #2;
            if (!ok) waits++;
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL accept_timeout: got no in_ready want in_ready within 50 cycles");
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.a = W'($urandom); bus.b = W'($urandom); bus.is_signed = 1'($urandom);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input bit rel_first,
                          output logic [2*W-1:0] p, output logic o, output int lat, output int waits);
        bit seen;
        if (rel_first) begin
            bus.out_ready = 1'b1;
            @(posedge clk);
            #2;
            bus.out_ready = 1'b0;
        end
        send(a, b, s, waits);
        seen = 0;
        lat = 0;
        for (int n = 1; n <= 40 && !seen; n++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) begin
                seen = 1;
                lat  = n;
            end
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL result_timeout: got no out_valid want out_valid within 40 cycles");
        end
        p = bus.product;
        o = bus.ovf;
    endtask

    initial begin
        logic [2*W-1:0] p, held_p;
        logic           o, held_o;
        int             lat, waits, stall;
        total = 0; bad = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.is_signed = 1'b0;
        bus.a = '0; bus.b = '0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        run_op(16'hFFFF, 16'hFFFF, 1'b0, 1'b1, p, o, lat, waits);
        chk("u_ffff_prod", p, 32'hFFFE0001);
        chk("u_ffff_ovf", o, 1'b1);
        chk("u_ffff_lat", lat, 16);

        run_op(16'hFFFD, 16'h0007, 1'b1, 1'b1, p, o, lat, waits);
        chk("s_m3x7_prod", p, 32'hFFFFFFEB);
        chk("s_m3x7_ovf", o, 1'b0);

        run_op(16'h8000, 16'h8000, 1'b1, 1'b1, p, o, lat, waits);
        chk("s_minmin_prod", p, 32'h40000000);
        chk("s_minmin_ovf", o, 1'b1);

        // Backpressure: result must hold while the consumer stalls, then release and accept together.
        run_op(16'h1234, 16'h0056, 1'b0, 1'b1, p, o, lat, waits);
        held_p = p; held_o = o;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_product", bus.product, held_p);
            chk("bp_ovf", bus.ovf, held_o);
            chk("bp_in_ready", bus.in_ready, 1'b0);
        end
        run_op(16'h0002, 16'h0003, 1'b0, 1'b0, p, o, lat, waits);
        chk("b2b_waits", waits, 0);
        chk("b2b_prod", p, 32'h00000006);

        run_op(16'h0005, 16'h0003, 1'b0, 1'b1, p, o, lat, waits);
        chk("et_5x3_prod", p, 32'h0000000F);
`ifdef MUL_EARLY_TERM_EN
        chk("et_5x3_lat", lat, 2);
`else
        chk("et_5x3_lat", lat, 16);
`endif
        run_op(16'h1234, 16'h0000, 1'b0, 1'b1, p, o, lat, waits);
        chk("et_b0_prod", p, 32'h00000000);
`ifdef MUL_EARLY_TERM_EN
        chk("et_b0_lat", lat, 1);
`else
        chk("et_b0_lat", lat, 16);
`endif

        // Leave a nonzero product behind, then abort a new op mid-run with reset.
        run_op(16'h0123, 16'h0456, 1'b0, 1'b1, p, o, lat, waits);
        send(16'h0009, 16'hFFFF, 1'b0, waits);
        repeat (7) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_out_valid", bus.out_valid, 1'b0);
        chk("abort_product", bus.product, 32'h0);
        chk("abort_in_ready", bus.in_ready, 1'b0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("post_rst_in_ready", bus.in_ready, 1'b1);
        #1;
        run_op(16'd10, 16'd10, 1'b0, 1'b1, p, o, lat, waits);
        chk("post_rst_prod", p, 32'h00000064);

        for (int i = 0; i < 2000; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), bit'($urandom_range(0, 1)), p, o, lat, waits);
            stall = $urandom_range(0, 3);
            repeat (stall) begin
                @(posedge clk);
                #2;
            end
        end
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2 bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
